// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined MIPS main control: opcodes, ALUOp classes,
// packed control-bundle layout and the per-stage control subsets.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  localparam int unsigned B_JUMP       = 0;
  localparam int unsigned B_BNE        = 1;
  localparam int unsigned B_BRANCH     = 2;
  localparam int unsigned B_MEM_TO_REG = 3;
  localparam int unsigned B_REG_WRITE  = 4;
  localparam int unsigned B_MEM_WRITE  = 5;
  localparam int unsigned B_MEM_READ   = 6;
  localparam int unsigned B_ALU_OP_LO  = 7;
  localparam int unsigned B_ALU_OP_HI  = 8;
  localparam int unsigned B_ALU_SRC    = 9;
  localparam int unsigned B_REG_DST    = 10;
  localparam int unsigned BUNDLE_W     = 11;

  typedef logic [BUNDLE_W-1:0] bundle_t;

  localparam bundle_t BUNDLE_NOP = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic     mem_read;
    logic     mem_write;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    mem_ctrl_t  mem;
  } ex_ctrl_t;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic rt_is_source(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode-to-control-bundle decoder; unknown opcodes
// decode to the all-zero NOP bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output bundle_t    bundle_o
);

  always_comb begin
    bundle_o = BUNDLE_NOP;
    case (opcode_i)
      OP_RTYPE: begin
        bundle_o[B_REG_DST]                = 1'b1;
        bundle_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_FUNCT;
        bundle_o[B_REG_WRITE]              = 1'b1;
        bundle_o[B_MEM_TO_REG]             = 1'b1;
      end
      OP_ADDI: begin
        bundle_o[B_ALU_SRC]                = 1'b1;
        bundle_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_ADD;
        bundle_o[B_REG_WRITE]              = 1'b1;
        bundle_o[B_MEM_TO_REG]             = 1'b1;
      end
      OP_ANDI: begin
        bundle_o[B_ALU_SRC]                = 1'b1;
        bundle_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_AND;
        bundle_o[B_REG_WRITE]              = 1'b1;
        bundle_o[B_MEM_TO_REG]             = 1'b1;
      end
      OP_BEQ: begin
        bundle_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_SUB;
        bundle_o[B_BRANCH]                 = 1'b1;
      end
      OP_BNE: begin
        bundle_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_SUB;
        bundle_o[B_BNE]                    = 1'b1;
      end
      OP_LW: begin
        bundle_o[B_ALU_SRC]                = 1'b1;
        bundle_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_ADD;
        bundle_o[B_MEM_READ]               = 1'b1;
        bundle_o[B_REG_WRITE]              = 1'b1;
      end
      OP_SW: begin
        bundle_o[B_ALU_SRC]                = 1'b1;
        bundle_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_ADD;
        bundle_o[B_MEM_WRITE]              = 1'b1;
      end
      OP_J: begin
        bundle_o[B_JUMP]                   = 1'b1;
      end
      default: bundle_o = BUNDLE_NOP;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: decodes in ID, carries control and destination
// through ID/EX, EX/MEM, MEM/WB, and inserts load-use bubbles.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned ALUOP_W       = 2,
  parameter bit          HAZARD_DETECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_flush,
  output logic                  stall,
  output logic                  id_branch,
  output logic                  id_bne,
  output logic                  id_jump,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic [REG_ADDR_W-1:0] wb_dst
);

  bundle_t                 id_bundle;
  logic [REG_ADDR_W-1:0]   id_dst;
  logic                    hazard;
  logic                    load_bubble;

  ex_ctrl_t                idex_d, idex_q;
  logic [REG_ADDR_W-1:0]   idex_dst_d, idex_dst_q;
  mem_ctrl_t               exmem_q;
  logic [REG_ADDR_W-1:0]   exmem_dst_q;
  wb_ctrl_t                memwb_q;
  logic [REG_ADDR_W-1:0]   memwb_dst_q;

  ctrl_decode u_decode (
    .opcode_i (opcode),
    .bundle_o (id_bundle)
  );

  always_comb begin
    id_dst = '0;
    if (id_bundle[B_REG_WRITE]) begin
      id_dst = id_bundle[B_REG_DST] ? id_rd : id_rt;
    end
  end

  assign hazard = id_valid && idex_q.mem.mem_read && (idex_dst_q != '0) &&
                  ((idex_dst_q == id_rs) || (rt_is_source(opcode) && (idex_dst_q == id_rt)));

  // A flush outranks the stall: the squashed instruction must not hold the front end.
  assign stall       = HAZARD_DETECT && hazard && !id_flush;
  assign load_bubble = !id_valid || id_flush || stall;

  assign id_branch = id_bundle[B_BRANCH] && !load_bubble;
  assign id_bne    = id_bundle[B_BNE]    && !load_bubble;
  assign id_jump   = id_bundle[B_JUMP]   && !load_bubble;

  always_comb begin
    idex_d     = '0;
    idex_dst_d = '0;
    if (!load_bubble) begin
      idex_d.reg_dst           = id_bundle[B_REG_DST];
      idex_d.alu_src           = id_bundle[B_ALU_SRC];
      idex_d.alu_op            = id_bundle[B_ALU_OP_HI:B_ALU_OP_LO];
      idex_d.mem.mem_read      = id_bundle[B_MEM_READ];
      idex_d.mem.mem_write     = id_bundle[B_MEM_WRITE];
      idex_d.mem.wb.reg_write  = id_bundle[B_REG_WRITE];
      idex_d.mem.wb.mem_to_reg = id_bundle[B_MEM_TO_REG];
      idex_dst_d               = id_dst;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q      <= '0;
      idex_dst_q  <= '0;
      exmem_q     <= '0;
      exmem_dst_q <= '0;
      memwb_q     <= '0;
      memwb_dst_q <= '0;
    end else begin
      idex_q      <= idex_d;
      idex_dst_q  <= idex_dst_d;
      exmem_q     <= idex_q.mem;
      exmem_dst_q <= idex_dst_q;
      memwb_q     <= exmem_q.wb;
      memwb_dst_q <= exmem_dst_q;
    end
  end

  assign ex_reg_dst    = idex_q.reg_dst;
  assign ex_alu_src    = idex_q.alu_src;
  assign ex_alu_op     = ALUOP_W'(idex_q.alu_op);
  assign ex_dst        = idex_dst_q;
  assign mem_read      = exmem_q.mem_read;
  assign mem_write     = exmem_q.mem_write;
  assign mem_dst       = exmem_dst_q;
  assign wb_reg_write  = memwb_q.reg_write;
  assign wb_mem_to_reg = memwb_q.mem_to_reg;
  assign wb_dst        = memwb_dst_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed-vector scoreboard bench for pipe_ctrl_unit: each applied vector
// queues its hand-computed per-cycle response, a negedge monitor checks it.
module tb_pipe_ctrl_unit;

  localparam int R    = 6'b000000;
  localparam int ADDI = 6'b001000;
  localparam int ANDI = 6'b001100;
  localparam int BEQ  = 6'b000100;
  localparam int BNE  = 6'b000101;
  localparam int LW   = 6'b100011;
  localparam int SW   = 6'b101011;
  localparam int J    = 6'b000010;
  localparam int BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_flush = 1'b0;
  logic       stall, id_branch, id_bne, id_jump;
  logic       ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
  logic [4:0] ex_dst, mem_dst, wb_dst;

  pipe_ctrl_unit #(
    .REG_ADDR_W    (5),
    .ALUOP_W       (2),
    .HAZARD_DETECT (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .opcode        (opcode),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_flush      (id_flush),
    .stall         (stall),
    .id_branch     (id_branch),
    .id_bne        (id_bne),
    .id_jump       (id_jump),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .ex_dst        (ex_dst),
    .mem_dst       (mem_dst),
    .wb_dst        (wb_dst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, vld, op, rs, rt, rd, fl;
  } stim_t;

  typedef struct {
    int idx;
    int st, br, bn, jm, erd, eas, eop, mr, mw, wrw, wm, exd, memd, wbd;
  } exp_t;

  stim_t stim_tab[$];
  exp_t  exp_tab[$];
  exp_t  exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  task automatic v(input int rst, vld, op, rs, rt, rd, fl,
                   input int st, br, bn, jm, erd, eas, eop,
                   input int mr, mw, wrw, wm, exd, memd, wbd);
    stim_t s;
    exp_t  e;
    s.rst = rst; s.vld = vld; s.op = op; s.rs = rs; s.rt = rt; s.rd = rd; s.fl = fl;
    e.idx = stim_tab.size();
    e.st = st; e.br = br; e.bn = bn; e.jm = jm; e.erd = erd; e.eas = eas; e.eop = eop;
    e.mr = mr; e.mw = mw; e.wrw = wrw; e.wm = wm; e.exd = exd; e.memd = memd; e.wbd = wbd;
    stim_tab.push_back(s);
    exp_tab.push_back(e);
  endtask

  task automatic chk(input int idx, input string name, input int act, input int expv);
    if (act != expv) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents one control snapshot.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      chk(e.idx, "stall",         int'(stall),         e.st);
      chk(e.idx, "id_branch",     int'(id_branch),     e.br);
      chk(e.idx, "id_bne",        int'(id_bne),        e.bn);
      chk(e.idx, "id_jump",       int'(id_jump),       e.jm);
      chk(e.idx, "ex_reg_dst",    int'(ex_reg_dst),    e.erd);
      chk(e.idx, "ex_alu_src",    int'(ex_alu_src),    e.eas);
      chk(e.idx, "ex_alu_op",     int'(ex_alu_op),     e.eop);
      chk(e.idx, "mem_read",      int'(mem_read),      e.mr);
      chk(e.idx, "mem_write",     int'(mem_write),     e.mw);
      chk(e.idx, "wb_reg_write",  int'(wb_reg_write),  e.wrw);
      chk(e.idx, "wb_mem_to_reg", int'(wb_mem_to_reg), e.wm);
      chk(e.idx, "ex_dst",        int'(ex_dst),        e.exd);
      chk(e.idx, "mem_dst",       int'(mem_dst),       e.memd);
      chk(e.idx, "wb_dst",        int'(wb_dst),        e.wbd);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //  rst vld op    rs rt rd fl   st br bn jm  erd eas eop  mr mw wrw wm  exd memd wbd
    v(0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 1, R,    1, 2, 3, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 1, ADDI, 3, 4, 0, 0,   0, 0, 0, 0,  1, 0, 2,   0, 0, 0, 0,   3, 0, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0,   4, 3, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1,   0, 4, 3);
    v(1, 1, LW,   1, 5, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1,   0, 0, 4);
    v(1, 1, R,    5, 2, 6, 0,   1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0,   5, 0, 0);
    v(1, 1, R,    5, 2, 6, 0,   0, 0, 0, 0,  0, 0, 0,   1, 0, 0, 0,   0, 5, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  1, 0, 2,   0, 0, 1, 0,   6, 0, 5);
    v(1, 1, LW,   1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 6, 0);
    v(1, 1, R,    0, 2, 6, 0,   0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 1,   0, 0, 6);
    v(1, 1, LW,   1, 5, 0, 0,   0, 0, 0, 0,  1, 0, 2,   1, 0, 0, 0,   6, 0, 0);
    v(1, 1, BEQ,  5, 7, 0, 1,   0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0,   5, 6, 0);
    v(1, 1, BEQ,  1, 2, 0, 0,   0, 1, 0, 0,  0, 0, 0,   1, 0, 1, 1,   0, 5, 6);
    v(1, 1, BNE,  1, 2, 0, 0,   0, 0, 1, 0,  0, 0, 1,   0, 0, 1, 0,   0, 0, 5);
    v(1, 1, J,    0, 0, 0, 0,   0, 0, 0, 1,  0, 0, 1,   0, 0, 0, 0,   0, 0, 0);
    v(1, 1, BAD,  3, 4, 5, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 1, LW,   2, 7, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 1, ADDI, 1, 7, 0, 0,   0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0,   7, 0, 0);
    v(1, 1, LW,   2, 9, 0, 0,   0, 0, 0, 0,  0, 1, 0,   1, 0, 0, 0,   7, 7, 0);
    v(1, 1, SW,   3, 9, 0, 0,   1, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0,   9, 7, 7);
    v(1, 1, SW,   3, 9, 0, 0,   0, 0, 0, 0,  0, 0, 0,   1, 0, 1, 1,   0, 9, 7);
    v(1, 1, LW,   1, 5, 0, 0,   0, 0, 0, 0,  0, 1, 0,   0, 0, 1, 0,   0, 0, 9);
    v(1, 1, LW,   1, 6, 0, 0,   0, 0, 0, 0,  0, 1, 0,   0, 1, 0, 0,   5, 0, 0);
    v(0, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 1, ANDI, 1, 10, 0, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 1, 3,   0, 0, 0, 0,   10, 0, 0);
    v(1, 0, BEQ,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 10, 0);
    v(1, 0, 0,    0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 1,   0, 0, 10);

    for (int i = 0; i < stim_tab.size(); i++) begin
      @(posedge clk);
      #1;
      reset    = 1'(stim_tab[i].rst);
      id_valid = 1'(stim_tab[i].vld);
      opcode   = 6'(stim_tab[i].op);
      id_rs    = 5'(stim_tab[i].rs);
      id_rt    = 5'(stim_tab[i].rt);
      id_rd    = 5'(stim_tab[i].rd);
      id_flush = 1'(stim_tab[i].fl);
      exp_q.push_back(exp_tab[i]);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d snapshots left unchecked, expected 0", exp_q.size());
    end
    if (n_vec != exp_tab.size()) begin
      n_miss++;
      $display("FAIL count: checked %0d snapshots, expected %0d", n_vec, exp_tab.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined main control for the five-stage MIPS datapath. Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers, together with the destination register number. Detects load-use hazards and inserts bubbles. Applies ID-stage flush requests. Supersedes the purely combinational decoder as the single owner of per-stage control signals.

## Interface
- REG_ADDR_W, 5, register-number width
- ALUOP_W, 2, width of ALUOp field
- HAZARD_DETECT, 1, 1 = load-use stall logic present; 0 = stall tied low
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all pipeline state
- id_valid  input  1  IF/ID holds a real instruction
- opcode  input  6  instr[31:26] in ID
- id_rs  input  REG_ADDR_W  instr[25:21]
- id_rt  input  REG_ADDR_W  instr[20:16]
- id_rd  input  REG_ADDR_W  instr[15:11]
- id_flush  input  1  squash the instruction currently in ID
- stall  output  1  hold PC and IF/ID this cycle
- id_branch, id_bne, id_jump  output  1 each  ID-stage branch/jump controls
- ex_reg_dst, ex_alu_src  output  1 each  EX controls
- ex_alu_op  output  ALUOP_W  EX ALU op class
- mem_read, mem_write  output  1 each  MEM controls
- wb_reg_write, wb_mem_to_reg  output  1 each  WB controls (mem_to_reg=1 selects ALU result, 0 selects load data)
- ex_dst, mem_dst, wb_dst  output  REG_ADDR_W each  destination register per stage (0 when no write)

## Operation
- Decode, fields {RegDst,ALUSrc,ALUOp,MemRead,MemWrite,RegWrite,MemtoReg,Branch,Bne,Jump}:
- 000000 R-type: 1,0,10,0,0,1,1,0,0,0
- 001000 addi: 0,1,00,0,0,1,1,0,0,0
- 001100 andi: 0,1,11,0,0,1,1,0,0,0
- 000100 beq: 0,0,01,0,0,0,0,1,0,0
- 000101 bne: 0,0,01,0,0,0,0,0,1,0
- 100011 lw: 0,1,00,1,0,1,0,0,0,0
- 101011 sw: 0,1,00,0,1,0,0,0,0,0
- 000010 j: all zero except Jump=1
- Any other opcode: all zero (NOP bundle).
- Destination = RegDst ? id_rd : id_rt; forced to 0 when RegWrite=0.
- The bubble is the all-zero bundle with dst=0.
- Hazard: ex_mem_read && ex_dst!=0 && (ex_dst==id_rs || (ex_dst==id_rt && opcode in {R-type,beq,bne,sw})) && id_valid.
- stall = HAZARD_DETECT && hazard && !id_flush.
- ID/EX load value: bubble if !id_valid, id_flush or stall; otherwise the decoded bundle.
- EX/MEM and MEM/WB always advance. They are never stalled or flushed by this block.
- id_branch/id_bne/id_jump are combinational from opcode, gated to 0 when !id_valid, stall or id_flush.

## Timing
- Decode and stall are combinational in ID.
- An instruction in ID at cycle n drives ex_* at n+1, mem_* at n+2 and wb_* at n+3.
- Reset asserted: every registered output is 0 immediately (asynchronous). stall is 0 and the id_* outputs are 0 until id_valid.
- Reset released mid-stream: pipeline restarts empty. No stale control reappears.
- A stall lasts exactly one cycle per load-use pair. The bubble then occupies EX, and the following cycle re-evaluates with ex_mem_read=0.
- Simultaneous id_flush and hazard: stall=0 and a bubble is loaded.
- A lw to $0 never stalls.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_ANDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J)
  - ALUOp encodings (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10, ALU_AND=11)
  - bit positions of the packed control bundle, with BUNDLE_W
- One sub-module, ctrl_decode: purely combinational opcode-to-bundle decoder, instantiated once.
- Hazard compare and the three stage registers live in pipe_ctrl_unit.

## Test plan
- Reset low mid-stream with lw in EX:
  - all ex_/mem_/wb_ outputs and dst outputs go 0 the same cycle.
  - after release, NOP bubbles flow for 3 cycles.
- Sequence R-type add $3,$1,$2 then addi $4,$3,5 (no stall):
  - ex_reg_dst=1, ex_alu_op=10, ex_dst=3 at n+1.
  - wb_reg_write=1, wb_mem_to_reg=1, wb_dst=3 at n+3.
  - the addi follows one cycle behind with ex_dst=4, ex_alu_src=1.
- lw $5,0($1) then add $6,$5,$2:
  - stall=1 for exactly one cycle.
  - ex_* is the bubble that cycle.
  - mem_read=1 at n+2, and the add reaches EX one cycle late.
- lw $0,0($1) then add $6,$0,$2: stall never asserts.
- lw $5 then beq $5,$7 with id_flush=1 on the beq cycle:
  - stall=0, id_branch=0.
  - bubble loaded into EX.
- Undefined opcode 111111 with id_valid=1: NOP bundle propagates, and all dst outputs are 0 at every stage.
